multiplicador_4b: RTL and testbench

Push-button 4-bit multiplier front panel, the inverse-operation companion to the team's 4-bit divider board. The operator enters two 4-bit operands with up/down buttons and steps through the phases with ok. A sequential shift-add unit forms the 8-bit product, and the board shows it on the same 4 LEDs as high nibble, then low nibble. It shares the board pinout (buttons, clock, reset, leds) with the divider so either image can be loaded.

---
 rtl/multiplicador_4b.sv | 140 ++++++++++++++
 tb/tb_multiplicador_4b.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_4b.sv
// Push-button 4-bit multiplier front panel: operand entry with up/down/ok,
// sequential shift-add product, result shown as high then low nibble on 4 LEDs.
module multiplicador_4b (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       down,
   input  logic       ok,
   output logic [3:0] leds,
   output logic       busy
);

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      SHOW_HI = 2'd2,
      SHOW_LO = 2'd3
   } phase_e;

   // Button conditioning, bit order {ok, down, up}; released level is 1.
   logic [2:0] s1_q, s2_q, s3_q;
   logic [2:0] btn_ev;
   logic       up_ev, down_ev, ok_ev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 3'b111;
         s2_q <= 3'b111;
         s3_q <= 3'b111;
      end else begin
         s1_q <= {ok, down, up};
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign btn_ev  = ~s2_q & s3_q;
   assign up_ev   = btn_ev[0];
   assign down_ev = btn_ev[1];
   assign ok_ev   = btn_ev[2];

   phase_e     phase_q,   phase_d;
   logic [3:0] a_q,       a_d;
   logic [3:0] b_q,       b_d;
   logic [7:0] acc_q,     acc_d;
   logic [7:0] mcand_q,   mcand_d;
   logic [3:0] mplier_q,  mplier_d;
   logic [1:0] cnt_q,     cnt_d;
   logic       busy_q,    busy_d;
   logic [7:0] product_q, product_d;
   logic [7:0] acc_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q   <= ENTER_A;
         a_q       <= 4'd0;
         b_q       <= 4'd0;
         acc_q     <= 8'd0;
         mcand_q   <= 8'd0;
         mplier_q  <= 4'd0;
         cnt_q     <= 2'd0;
         busy_q    <= 1'b0;
         product_q <= 8'd0;
      end else begin
         phase_q   <= phase_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         product_q <= product_d;
      end
   end

   // NOTE: every next-state signal gets its hold value first, so no latch can be inferred.
   always_comb begin
      phase_d   = phase_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      product_d = product_q;
      acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 8'd0);

      if (busy_q) begin
         acc_d    = acc_sum;
         mcand_d  = {mcand_q[6:0], 1'b0};
         mplier_d = {1'b0, mplier_q[3:1]};
         cnt_d    = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            product_d = acc_sum;
            busy_d    = 1'b0;
         end
      end

      // ok takes priority over up/down in the same cycle, and is dropped while iterating.
      if (ok_ev) begin
         if (!busy_q) begin
            unique case (phase_q)
               ENTER_A: phase_d = ENTER_B;
               ENTER_B: begin
                  phase_d  = SHOW_HI;
                  acc_d    = 8'd0;
                  mcand_d  = {4'b0000, a_q};
                  mplier_d = b_q;
                  cnt_d    = 2'd0;
                  busy_d   = 1'b1;
               end
               SHOW_HI: phase_d = SHOW_LO;
               SHOW_LO: phase_d = ENTER_A;
            endcase
         end
      end else if (up_ev ^ down_ev) begin
         unique case (phase_q)
            ENTER_A: a_d = up_ev ? a_q + 4'd1 : a_q - 4'd1;
            ENTER_B: b_d = up_ev ? b_q + 4'd1 : b_q - 4'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      leds = 4'd0;
      unique case (phase_q)
         ENTER_A: leds = a_q;
         ENTER_B: leds = b_q;
         SHOW_HI: leds = busy_q ? 4'd0 : product_q[7:4];
         SHOW_LO: leds = product_q[3:0];
      endcase
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_multiplicador_4b.sv
// Self-checking bench for multiplicador_4b: directed button sequences plus random
// operand pairs, compared against an arithmetic model of the front panel.
module tb_multiplicador_4b;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       up = 1'b1, down = 1'b1, ok = 1'b1;
   logic [3:0] leds;
   logic       busy;

   int n_pass = 0;
   int n_total = 0;

   // Reference model of the panel: phase, operands, last product.
   int ph = 0;
   int ma = 0;
   int mb = 0;
   logic [7:0] mprod = 8'd0;

   multiplicador_4b dut (
      .clk  (clk),
      .rst  (rst),
      .up   (up),
      .down (down),
      .ok   (ok),
      .leds (leds),
      .busy (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // which: 0 up, 1 down, 2 ok, 3 up+down, 4 ok+up
   task automatic press(input int which);
      case (which)
         0: up = 1'b0;
         1: down = 1'b0;
         2: ok = 1'b0;
         3: begin up = 1'b0; down = 1'b0; end
         default: begin ok = 1'b0; up = 1'b0; end
      endcase
      tick(4);
      up = 1'b1; down = 1'b1; ok = 1'b1;
      tick(4);
   endtask

   // Steps the operand of the current entry phase to target along the shorter way round.
   task automatic set_val(input int target);
      int cur;
      cur = (ph == 0) ? ma : mb;
      while (cur != target) begin
         if (((target - cur + 16) % 16) <= 8) begin
            press(0);
            cur = (cur + 1) % 16;
         end else begin
            press(1);
            cur = (cur + 15) % 16;
         end
      end
      if (ph == 0) ma = cur; else mb = cur;
   endtask

   task automatic run_mult(input int a, input int b, input bit poke);
      int lat;
      int nb;
      if (ph == 0) begin
         set_val(a);
         check("a_entry", {4'd0, leds}, 8'(ma));
         press(2);
         ph = 1;
         check("b_retained", {4'd0, leds}, 8'(mb));
      end
      set_val(b);
      check("b_entry", {4'd0, leds}, 8'(mb));
      mprod = 8'(ma * mb);

      ok = 1'b0;
      lat = 99;
      for (int t = 1; t <= 10; t++) begin
         tick(1);
         if (busy === 1'b1) begin
            lat = t;
            break;
         end
      end
      ok = 1'b1;
      ph = 2;
      check("busy_latency", 8'(lat), 8'd3);
      check("leds_zero_busy", {4'd0, leds}, 8'd0);

      nb = 1;
      while (busy === 1'b1 && nb < 20) begin
         tick(1);
         if (poke && nb == 1) ok = 1'b0;
         if (busy === 1'b1) nb++;
      end
      check("busy_cycles", 8'(nb), 8'd4);
      tick(2);
      ok = 1'b1;
      tick(4);

      check("show_hi", {4'd0, leds}, {4'd0, mprod[7:4]});
      press(2);
      ph = 3;
      check("show_lo", {4'd0, leds}, {4'd0, mprod[3:0]});
      press(0);
      check("show_lo_up_ignored", {4'd0, leds}, {4'd0, mprod[3:0]});
      press(2);
      ph = 0;
      check("wrap_to_a", {4'd0, leds}, 8'(ma));
   endtask

   task automatic model_reset();
      ph = 0;
      ma = 0;
      mb = 0;
      mprod = 8'd0;
   endtask

   initial begin
      int lat;

      #2 rst = 1'b0;
      tick(2);
      check("reset_leds", {4'd0, leds}, 8'd0);
      check("reset_busy", {7'd0, busy}, 8'd0);
      rst = 1'b1;
      tick(2);

      set_val(3);
      check("up_x3", {4'd0, leds}, 8'h3);
      set_val(2);
      check("down_x1", {4'd0, leds}, 8'h2);
      rst = 1'b0;
      #1;
      check("midtest_reset_leds", {4'd0, leds}, 8'd0);
      check("midtest_reset_busy", {7'd0, busy}, 8'd0);
      tick(2);
      rst = 1'b1;
      tick(2);
      model_reset();

      press(1);
      ma = 15;
      check("wrap_down", {4'd0, leds}, 8'hF);
      press(0);
      ma = 0;
      check("wrap_up", {4'd0, leds}, 8'h0);
      press(3);
      check("up_down_same_cycle", {4'd0, leds}, 8'h0);

      set_val(5);
      press(4);
      ph = 1;
      check("ok_beats_up_phase", {4'd0, leds}, 8'(mb));
      run_mult(5, 0, 1'b0);

      run_mult(13, 11, 1'b0);
      run_mult(15, 15, 1'b0);
      run_mult(0, 9, 1'b0);
      run_mult(1, 1, 1'b0);
      run_mult(6, 7, 1'b1);

      // Reset asserted during the second iteration.
      set_val(7);
      press(2);
      ph = 1;
      set_val(9);
      ok = 1'b0;
      lat = 99;
      for (int t = 1; t <= 10; t++) begin
         tick(1);
         if (busy === 1'b1) begin
            lat = t;
            break;
         end
      end
      ok = 1'b1;
      check("abort_busy_rise", 8'(lat), 8'd3);
      tick(1);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", {7'd0, busy}, 8'd0);
      check("abort_leds", {4'd0, leds}, 8'd0);
      tick(2);
      rst = 1'b1;
      tick(4);
      model_reset();
      check("abort_phase_a", {4'd0, leds}, 8'd0);
      run_mult(2, 3, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_mult(int'($urandom_range(15)), int'($urandom_range(15)), i == 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
